// File: rtl/calc_pkg.sv
// Shared calculator front-panel types: keypad scan states, scan results, column strobes.
// Used by keypad_scanner and keypad_debounce.
package calc_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [2:0] {
        DRV0 = 3'd0,
        SMP0 = 3'd1,
        DRV1 = 3'd2,
        SMP1 = 3'd3,
        DRV2 = 3'd4,
        SMP2 = 3'd5,
        DRV3 = 3'd6,
        SMP3 = 3'd7
    } scan_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } scan_res_e;

    localparam logic [3:0] COL0 = 4'b1000;
    localparam logic [3:0] COL1 = 4'b0100;
    localparam logic [3:0] COL2 = 4'b0010;
    localparam logic [3:0] COL3 = 4'b0001;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        case (idx)
            2'd0:    col_strobe = COL0;
            2'd1:    col_strobe = COL1;
            2'd2:    col_strobe = COL2;
            default: col_strobe = COL3;
        endcase
    endfunction

    // Row lines are wired reversed: ROW[3] is row 0, so bit r of the result is row r.
    function automatic logic [3:0] row_order(input logic [3:0] rows);
        row_order = {rows[0], rows[1], rows[2], rows[3]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-scan debounce: turns scan results into KEY/KEY_VALID/KEY_HELD; updates on the edge leaving SMP3.
// Optional auto-repeat under KEYPAD_REPEAT_EN.
module keypad_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 16
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic             scan_done,
    input  scan_res_e        scan_res,
    input  logic [KEY_W-1:0] scan_code,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic [KEY_W-1:0] cand;
    logic [3:0]       press_cnt;
    logic [3:0]       rel_cnt;
    logic             armed;
    logic [3:0]       press_nxt;
    logic [3:0]       rel_nxt;
    logic             rpt_fire;

    always_comb begin
        press_nxt = 4'd1;
        if (scan_code == cand)
            press_nxt = (press_cnt == DEB) ? DEB : press_cnt + 4'd1;
        rel_nxt = (rel_cnt == DEB) ? DEB : rel_cnt + 4'd1;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] RPT = 8'(REPEAT_SCANS);

    logic [7:0] rpt_cnt;
    logic       rpt_hit;

    assign rpt_hit  = key_held && (scan_res == ONE) && (scan_code == key);
    assign rpt_fire = scan_done && rpt_hit && (rpt_cnt == RPT - 8'd1);

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset)
            rpt_cnt <= 8'd0;
        else if (scan_done)
            rpt_cnt <= (rpt_hit && !rpt_fire) ? rpt_cnt + 8'd1 : 8'd0;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            cand      <= '0;
            press_cnt <= 4'd0;
            rel_cnt   <= 4'd0;
            armed     <= 1'b1;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (scan_res)
                    ONE: begin
                        cand      <= scan_code;
                        press_cnt <= press_nxt;
                        rel_cnt   <= 4'd0;
                        if (press_nxt == DEB && armed) begin
                            key       <= scan_code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            armed     <= 1'b0;
                        end else if (rpt_fire) begin
                            key_valid <= 1'b1;
                        end
                    end
                    NONE: begin
                        press_cnt <= 4'd0;
                        rel_cnt   <= rel_nxt;
                        if (rel_nxt == DEB) begin
                            armed    <= 1'b1;
                            key_held <= 1'b0;
                        end
                    end
                    default: begin
                        // Ghosting / multi-key: neither a press nor a release.
                        press_cnt <= 4'd0;
                        rel_cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: 8-state column scan, row capture, one-hot detection, debounced key output.
// KEYPAD_REPEAT_EN enables auto-repeat of a held key every REPEAT_SCANS scans.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 16
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic [3:0]       ROW,
    output logic [3:0]       COL,
    output logic [KEY_W-1:0] KEY,
    output logic             KEY_VALID,
    output logic             KEY_HELD
);

    scan_state_e      state;
    logic [11:0]      seen;
    logic [15:0]      hits;
    logic [4:0]       nbits;
    logic [KEY_W-1:0] scan_code;
    scan_res_e        scan_res;
    logic             scan_done;

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset)
            state <= DRV0;
        else
            state <= scan_state_e'(state + 3'd1);
    end

    assign COL       = col_strobe(state[2:1]);
    assign scan_done = (state == SMP3);

    // Columns 0-2 are held here; column 3 is taken live on the evaluating edge.
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            seen <= '0;
        end else begin
            case (state)
                SMP0:    seen[3:0]  <= row_order(ROW);
                SMP1:    seen[7:4]  <= row_order(ROW);
                SMP2:    seen[11:8] <= row_order(ROW);
                default: ;
            endcase
        end
    end

    // Bit index of hits is the key code {col_idx, row_idx}.
    assign hits = {row_order(ROW), seen};

    always_comb begin
        nbits     = 5'd0;
        scan_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (hits[i]) begin
                nbits     = nbits + 5'd1;
                scan_code = 4'(i);
            end
        end
        if (nbits == 5'd0)
            scan_res = NONE;
        else if (nbits == 5'd1)
            scan_res = ONE;
        else
            scan_res = MULTI;
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_SCANS  (REPEAT_SCANS)
    ) u_debounce (
        .slow_clock(slow_clock),
        .reset     (reset),
        .scan_done (scan_done),
        .scan_res  (scan_res),
        .scan_code (scan_code),
        .key       (KEY),
        .key_valid (KEY_VALID),
        .key_held  (KEY_HELD)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a set of pressed keys drives ROW from COL; a scan-level model predicts outputs.
module tb_keypad_scanner;

    localparam int DEB = 4;
    localparam int RPT = 16;

    logic       slow_clock = 1'b0;
    logic       reset      = 1'b0;
    logic [3:0] ROW        = 4'd0;
    logic [3:0] COL;
    logic [3:0] KEY;
    logic       KEY_VALID;
    logic       KEY_HELD;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, expressed in whole scans.
    int         m_press;
    int         m_rel;
    int         m_rpt;
    bit         m_armed;
    bit         m_held;
    bit         m_pulse;
    logic [3:0] m_key;
    logic [3:0] m_cand;

    always #5 slow_clock = ~slow_clock;

    keypad_scanner #(
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS  (RPT)
    ) dut (
        .slow_clock(slow_clock),
        .reset     (reset),
        .ROW       (ROW),
        .COL       (COL),
        .KEY       (KEY),
        .KEY_VALID (KEY_VALID),
        .KEY_HELD  (KEY_HELD)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_press = 0;
        m_rel   = 0;
        m_rpt   = 0;
        m_armed = 1'b1;
        m_held  = 1'b0;
        m_pulse = 1'b0;
        m_key   = 4'd0;
        m_cand  = 4'd0;
    endtask

    // Apply the debounce rules to one completed scan of the given key set.
    task automatic model_scan(input logic [15:0] keys);
        int         n;
        logic [3:0] code;
        bit         was_held;
        n        = $countones(keys);
        code     = 4'd0;
        was_held = m_held;
        m_pulse  = 1'b0;
        for (int i = 0; i < 16; i++)
            if (keys[i]) code = 4'(i);
        if (n == 1) begin
            if (code == m_cand) m_press = (m_press + 1 > DEB) ? DEB : m_press + 1;
            else                m_press = 1;
            m_cand = code;
            m_rel  = 0;
            if (m_press == DEB && m_armed) begin
                m_key   = code;
                m_pulse = 1'b1;
                m_held  = 1'b1;
                m_armed = 1'b0;
            end
        end else if (n == 0) begin
            m_press = 0;
            m_rel   = (m_rel + 1 > DEB) ? DEB : m_rel + 1;
            if (m_rel == DEB) begin
                m_armed = 1'b1;
                m_held  = 1'b0;
            end
        end else begin
            m_press = 0;
            m_rel   = 0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (was_held && n == 1 && code == m_key) begin
            m_rpt++;
            if (m_rpt == RPT) begin
                m_pulse = 1'b1;
                m_rpt   = 0;
            end
        end else begin
            m_rpt = 0;
        end
`else
        if (was_held) m_rpt = 0;
`endif
    endtask

    function automatic logic [3:0] rows_for(input logic [15:0] keys, input int col);
        logic [3:0] rv;
        for (int r = 0; r < 4; r++)
            rv[3 - r] = keys[col * 4 + r];
        return rv;
    endfunction

    // One full scan, entered just after the edge that starts DRV0.
    task automatic run_scan(input logic [15:0] keys, input bit noise);
        logic [3:0] exp_col;
        for (int p = 0; p < 8; p++) begin
            exp_col = 4'b1000 >> (p / 2);
            if (noise && (p % 2 == 0)) ROW = 4'($urandom);
            else                       ROW = rows_for(keys, p / 2);
            check_eq("col", {28'd0, COL}, {28'd0, exp_col});
            check_eq("key_valid", {31'd0, KEY_VALID}, (p == 0) ? {31'd0, m_pulse} : 32'd0);
            check_eq("key", {28'd0, KEY}, {28'd0, m_key});
            check_eq("key_held", {31'd0, KEY_HELD}, {31'd0, m_held});
            @(posedge slow_clock);
            #1;
        end
        model_scan(keys);
    endtask

    task automatic run_scans(input logic [15:0] keys, input int count, input bit noise);
        for (int s = 0; s < count; s++)
            run_scan(keys, noise);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("rst_col", {28'd0, COL}, 32'h8);
        check_eq("rst_key", {28'd0, KEY}, 32'd0);
        check_eq("rst_valid", {31'd0, KEY_VALID}, 32'd0);
        check_eq("rst_held", {31'd0, KEY_HELD}, 32'd0);
        ROW = 4'd0;
        repeat (2) @(posedge slow_clock);
        #1;
        reset = 1'b1;
    endtask

    localparam logic [15:0] K6   = 16'h0040;
    localparam logic [15:0] KF   = 16'h8000;
    localparam logic [15:0] KMUL = 16'h0201;

    initial begin
        logic [15:0] keys;
        int          sel;
        model_reset();
        @(posedge slow_clock);
        #1;
        do_reset();

        run_scans(16'h0, 2, 1'b0);

        run_scans(K6, 7, 1'b0);
        run_scans(16'h0, 4, 1'b0);

        run_scans(K6, 3, 1'b0);
        run_scans(16'h0, 1, 1'b0);
        run_scans(K6, 5, 1'b0);
        run_scans(16'h0, 4, 1'b0);

        run_scans(KMUL, 10, 1'b0);
        run_scans(16'h0, 4, 1'b0);

        run_scans(K6, 4, 1'b0);
        run_scans(16'h0, 3, 1'b0);
        run_scans(K6, 5, 1'b0);
        run_scans(16'h0, 4, 1'b0);
        run_scans(KF, 5, 1'b0);
        run_scans(16'h0, 4, 1'b0);

        run_scans(K6, 3, 1'b0);
        for (int p = 0; p < 3; p++) begin
            ROW = rows_for(K6, p / 2);
            @(posedge slow_clock);
            #1;
        end
        do_reset();
        run_scans(K6, 5, 1'b0);
        run_scans(16'h0, 4, 1'b0);

`ifdef KEYPAD_REPEAT_EN
        run_scans(KF, 40, 1'b0);
        run_scans(16'h0, 4, 1'b0);
`endif

        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      keys = 16'h0;
            else if (sel < 8) keys = 16'h1 << $urandom_range(0, 15);
            else              keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            run_scans(keys, $urandom_range(1, 6), 1'b1);
        end
        run_scans(16'h0, 1, 1'b1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
